// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the blocks that share the memory_controller port.
package mem_ctrl_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] NO_BAD_ADDR = '1;

endpackage

// File: rtl/mem_verify_cmp.sv
// Read-return compare stage: tracks the read in flight, counts mismatching bytes
// with saturation and keeps the address of the first one.
module mem_verify_cmp
   import mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              issue_vld,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [7:0]        rd_data,
   input  logic [7:0]        exp_data,
   output logic              mismatch,
   output logic [31:0]       return_val,
   output logic [ADDR_W-1:0] first_bad_addr
);

   logic              rd_vld_p1;
   logic [ADDR_W-1:0] rd_addr_p1;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // p0 -> p1: the address issued this cycle returns data next cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_vld_p1 <= 1'b0;
      else        rd_vld_p1 <= issue_vld;
   end

   always_ff @(posedge clk) begin
      rd_addr_p1 <= issue_addr;
   end

   assign mismatch = rd_vld_p1 && (rd_data != exp_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         return_val     <= '0;
         first_bad_addr <= NO_BAD_ADDR;
      end else if (clr) begin
         return_val     <= '0;
         first_bad_addr <= NO_BAD_ADDR;
      end else if (mismatch) begin
         return_val <= sat_inc(return_val);
         if (first_bad_addr == NO_BAD_ADDR) first_bad_addr <= rd_addr_p1;
      end
   end

endmodule

// File: rtl/mem_verify.sv
// Read-back checker for a memset fill over the memory_controller port.
// Optional MEM_VERIFY_STOP_ON_FAIL_EN: abort to DONE on the first mismatching byte.
module mem_verify
   import mem_ctrl_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] m,
   input  logic [31:0]       c,
   input  logic [31:0]       n,
   output logic              finish,
   output logic [31:0]       return_val,
   output logic [ADDR_W-1:0] first_bad_addr,
   output logic [ADDR_W-1:0] memory_controller_address,
   output logic              memory_controller_write_enable,
   output logic [DATA_W-1:0] memory_controller_in,
   input  logic [DATA_W-1:0] memory_controller_out
);

   if (RD_LAT != 1) begin : g_rd_lat_chk
      $error("mem_verify only supports RD_LAT == 1");
   end

`ifdef MEM_VERIFY_STOP_ON_FAIL_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif

   state_t      state_q, state_d;
   logic [31:0] cnt_q;
   logic [31:0] n_q;
   logic [7:0]  exp_q;
   logic        accept;
   logic        mismatch;
   logic        abort;
   logic        unused_hi;

   assign accept = (state_q == IDLE) && start;
   assign abort  = STOP_EN && mismatch && ((state_q == ISSUE) || (state_q == DRAIN));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (n == 32'd0) ? DONE : ISSUE;
         ISSUE:   if (cnt_q == n_q - 32'd1) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = DONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Address generator: loaded on start, advances once per ISSUE cycle with modulo wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memory_controller_address <= '0;
      end else if (accept && (n != 32'd0)) begin
         memory_controller_address <= m;
      end else if (state_q == ISSUE) begin
         memory_controller_address <= memory_controller_address + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cnt_q <= '0;
         n_q   <= n;
         exp_q <= c[7:0];
      end else if (state_q == ISSUE) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   mem_verify_cmp u_cmp (
      .clk            (clk),
      .reset          (reset),
      .clr            (accept),
      .issue_vld      ((state_q == ISSUE) && !abort),
      .issue_addr     (memory_controller_address),
      .rd_data        (memory_controller_out[7:0]),
      .exp_data       (exp_q),
      .mismatch       (mismatch),
      .return_val     (return_val),
      .first_bad_addr (first_bad_addr)
   );

   assign finish                         = (state_q == DONE);
   assign memory_controller_write_enable = 1'b0;
   assign memory_controller_in           = '0;
   assign unused_hi = ^{c[31:8], memory_controller_out[DATA_W-1:8]};

endmodule

// File: doc/mem_verify.md
Name: mem_verify

Overview:
- Read-back checker that sits beside memset on the memory_controller port and consumes what memset wrote.
- After a fill, it walks n consecutive addresses starting at m and reads each byte through memory_controller.
- Each byte read is compared against the expected fill value c[7:0].
- It reports the mismatch count and the first failing address through the same start/finish handshake that memset uses.

Parameters:
- ADDR_W, 32, width of the address bus and of m.
- DATA_W, 32, width of the data buses. Only bits [7:0] are compared, matching the 8-bit RAM behind the controller.
- RD_LAT, 1, cycles from address presentation to valid memory_controller_out. Fixed at 1 for the current controller; the value is checked at elaboration.

Ports:
- clk  input  1  clock; all flops are rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- m  input  ADDR_W  base address.
- c  input  32  expected fill value; bits [7:0] are used.
- n  input  32  number of bytes to check.
- finish  output  1  one-cycle done pulse.
- return_val  output  32  mismatch count.
- first_bad_addr  output  ADDR_W  address of the first mismatch; all-ones if there was none.
- memory_controller_address  output  ADDR_W  read address.
- memory_controller_write_enable  output  1  always 0.
- memory_controller_in  output  DATA_W  always 0.
- memory_controller_out  input  DATA_W  read data, valid RD_LAT cycles after the address.

Behaviour:
- Reset (asserted low):
  - State goes to IDLE.
  - finish=0, return_val=0, first_bad_addr=all-ones, memory_controller_address=0, write_enable=0, in=0.
  - The read-valid pipeline bit is cleared.
- Reset mid-operation aborts immediately. No finish pulse is produced, and the block is idle on the first edge after reset releases.
- States:
  - IDLE:
    - On start=1, latch m, c[7:0] and n.
    - Clear the counter i, return_val and first_bad_addr (to all-ones).
    - If n==0, go to DONE; otherwise go to ISSUE.
  - ISSUE:
    - memory_controller_address (registered) = m+i.
    - Each cycle: i<=i+1 and address<=address+1, with 32-bit modulo wrap.
    - When i==n-1, go to DRAIN.
  - DRAIN: one cycle for the final read return, then go to DONE.
  - DONE: finish=1 for exactly one cycle, then go to IDLE.
- Read pipeline:
  - rd_valid<=(state==ISSUE), and rd_addr<=the address issued in that cycle.
  - On a cycle with rd_valid=1, compare memory_controller_out[7:0] with the latched c[7:0].
  - On a mismatch:
    - return_val<=return_val+1, saturating at 32'hFFFFFFFF.
    - If first_bad_addr is still all-ones, first_bad_addr<=rd_addr.
- Latency: with start seen at edge t, finish is high during cycle t+n+2 for n>0, and during cycle t+1 for n==0.
- return_val and first_bad_addr hold their values until the next accepted start.
- start while not IDLE is ignored.
- memory_controller_write_enable is held 0 in every state, so mem_verify never writes.
- Only address bits [4:0] reach the 32x8 RAM. n>32 therefore re-reads aliased entries; this is intended, and each aliased read is counted.
- If m+i wraps past 32'hFFFFFFFF, the address wraps to 0 with no error flag.
- Ownership of memory_controller is exclusive. The top-level mux grants the port to mem_verify only while memset is in its idle state; mem_verify does not arbitrate.

Optional Feature:
- Macro: MEM_VERIFY_STOP_ON_FAIL_EN.
- Defined:
  - The first mismatch moves ISSUE or DRAIN directly to DONE on the next edge.
  - Any reads still in flight are discarded, so return_val is exactly 1 on failure.
  - finish comes early.
- Undefined: every one of the n bytes is checked; the only exit from ISSUE is the counter.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - ADDR_W and DATA_W.
  - State encodings IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, DONE=2'd3.
  - NO_BAD_ADDR, the all-ones constant.
- One natural sub-module: mem_verify_cmp. It holds the rd_valid/rd_addr pipeline, the compare, the saturating counter and the first-address capture. The FSM and address generator stay in mem_verify.

Test Plan:
1. memset fill: m=0, c=32'h5A, n=8, then mem_verify with the same arguments -> finish at t+10, return_val=0, first_bad_addr=32'hFFFFFFFF, write_enable never 1.
2. Preload RAM[3]=8'h00 and the rest 8'h5A, then m=0, c=8'h5A, n=8 -> return_val=1, first_bad_addr=3. With MEM_VERIFY_STOP_ON_FAIL_EN defined, finish comes at t+6.
3. n=0 -> finish at t+1, return_val=0, no address issued.
4. m=32'hFFFFFFFE, n=4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1 in consecutive cycles; the count matches the preloaded data.
5. n=40, all 8'h5A except RAM[2]=8'h00 -> return_val=2 (aliased re-read of entry 2), first_bad_addr=2.
6. Pull reset low at cycle 3 of ISSUE with n=20 -> outputs return to reset values immediately, no finish, and a new start after release runs a clean check.
